// File: rtl/nx_rbus_rr_arbiter_pkg.sv
// Shared types and helpers for the rbus round-robin arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   RBUS_*_BITS    : default rbus address/data widths
//   timer_bits()   : width of the ack-timeout timer
//   idx_bits()     : width of a requester index
package nx_rbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  localparam int RBUS_ADDR_BITS = 16;
  localparam int RBUS_DATA_BITS = 32;

  // A disabled timeout (0) still gets a 1-bit timer so the declarations stay legal.
  function automatic int timer_bits(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nx_rbus_rr_arbiter_if.sv
// Requester-side and rbus-side signals of the arbiter, bundled.
//   master : arbiter view (drives done/rdata/err/timeout/busy and the rbus strobes)
//   slave  : environment view (drives requests and the rbus response)
// Packed request vectors: slice n of req_addr/req_wdata belongs to requester n.
interface nx_rbus_rr_arbiter_if
  import nx_rbus_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_BITS = RBUS_ADDR_BITS,
  parameter int DATA_BITS = RBUS_DATA_BITS
);
  logic [N_REQ-1:0]           req;
  logic [N_REQ-1:0]           req_wr;
  logic [N_REQ*ADDR_BITS-1:0] req_addr;
  logic [N_REQ*DATA_BITS-1:0] req_wdata;
  logic [N_REQ-1:0]           req_done;
  logic                       req_err;
  logic [DATA_BITS-1:0]       req_rdata;
  logic                       timeout;
  logic                       busy;
  logic [ADDR_BITS-1:0]       rbus_addr;
  logic [DATA_BITS-1:0]       rbus_wr_data;
  logic                       rbus_wr_strb;
  logic                       rbus_rd_strb;
  logic [DATA_BITS-1:0]       rbus_rd_data;
  logic                       rbus_ack;
  logic                       rbus_err_ack;

  modport master (
    input  req, req_wr, req_addr, req_wdata, rbus_rd_data, rbus_ack, rbus_err_ack,
    output req_done, req_err, req_rdata, timeout, busy,
           rbus_addr, rbus_wr_data, rbus_wr_strb, rbus_rd_strb
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, rbus_rd_data, rbus_ack, rbus_err_ack,
    input  req_done, req_err, req_rdata, timeout, busy,
           rbus_addr, rbus_wr_data, rbus_wr_strb, rbus_rd_strb
  );
endinterface

// File: rtl/nx_rbus_rr_arbiter_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index granted most recently
//   grant      : first requester set at or after last_grant+1, wrapping
//   valid      : any request present
// Rotates the request vector so last_grant+1 lands at bit 0, priority-encodes
// the lowest set bit, then adds the rotation back to get the real index.
module nx_rr_pick
  import nx_rbus_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_bits(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             valid
);
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  int unsigned        start;

  always_comb begin
    start   = (int'(last_grant) + 1) % N_REQ;
    req_dbl = {req, req} >> start;
    req_rot = req_dbl[N_REQ-1:0];
    valid   = |req;
    grant   = '0;
    // Descending loop so the lowest rotated bit is the one that sticks.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) grant = IW'((start + i) % N_REQ);
    end
  end
endmodule

// File: rtl/nx_rbus_rr_arbiter.sv
// Round-robin arbiter sharing one rbus master port among N_REQ requesters.
// One transaction outstanding; optional ack timeout (TIMEOUT_CYCLES, 0 = off).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester vectors, completion outputs and rbus strobes/response
// All outputs are registered.
//
// state | meaning
// IDLE  | waiting for a request; picks a winner and fires its strobe
// WAIT  | strobe issued, waiting for ack/err_ack or timer expiry
// RSP   | one-cycle completion pulse to the granted requester
module nx_rbus_rr_arbiter
  import nx_rbus_arb_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int N_RBUS_ADDR_BITS = RBUS_ADDR_BITS,
  parameter int N_RBUS_DATA_BITS = RBUS_DATA_BITS,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nx_rbus_rr_arbiter_if.master bus
);
  localparam int IW = idx_bits(N_REQ);
  localparam int TW = timer_bits(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e                  state_q, state_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [IW-1:0]               grant_q, grant_d;
  logic [IW-1:0]               last_grant_q, last_grant_d;
  logic [N_RBUS_ADDR_BITS-1:0] addr_q, addr_d;
  logic [N_RBUS_DATA_BITS-1:0] wdata_q, wdata_d;
  logic                        wr_strb_q, wr_strb_d;
  logic                        rd_strb_q, rd_strb_d;
  logic [N_REQ-1:0]            done_q, done_d;
  logic                        err_q, err_d;
  logic [N_RBUS_DATA_BITS-1:0] rdata_q, rdata_d;
  logic                        timeout_q, timeout_d;
  logic                        busy_q;

  logic [IW-1:0]               pick_grant;
  logic                        pick_valid;
  logic                        resp;
  logic                        expire;

  nx_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign resp   = bus.rbus_ack | bus.rbus_err_ack;
  assign expire = TIMEOUT_EN && (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      grant_q      <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_strb_q    <= 1'b0;
      rd_strb_q    <= 1'b0;
      done_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_strb_q    <= wr_strb_d;
      rd_strb_q    <= rd_strb_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = WAIT;
      WAIT:    if (resp || expire) state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses default to 0 so each lasts one cycle.
  always_comb begin
    timer_d      = timer_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_strb_d    = 1'b0;
    rd_strb_d    = 1'b0;
    done_d       = '0;
    err_d        = 1'b0;
    rdata_d      = '0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_grant;
          addr_d    = bus.req_addr[int'(pick_grant)*N_RBUS_ADDR_BITS +: N_RBUS_ADDR_BITS];
          wdata_d   = bus.req_wdata[int'(pick_grant)*N_RBUS_DATA_BITS +: N_RBUS_DATA_BITS];
          wr_strb_d = bus.req_wr[pick_grant];
          rd_strb_d = ~bus.req_wr[pick_grant];
          timer_d   = '0;
        end
      end
      WAIT: begin
        // A response on the expiry cycle beats the timeout; err_ack beats ack.
        if (resp) begin
          done_d  = N_REQ'(1) << grant_q;
          err_d   = bus.rbus_err_ack;
          rdata_d = bus.rbus_rd_data;
        end else if (expire) begin
          done_d    = N_REQ'(1) << grant_q;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RSP: last_grant_d = grant_q;
      default: ;
    endcase
  end

  assign bus.req_done     = done_q;
  assign bus.req_err      = err_q;
  assign bus.req_rdata    = rdata_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = busy_q;
  assign bus.rbus_addr    = addr_q;
  assign bus.rbus_wr_data = wdata_q;
  assign bus.rbus_wr_strb = wr_strb_q;
  assign bus.rbus_rd_strb = rd_strb_q;
endmodule

// File: tb/tb_nx_rbus_rr_arbiter.sv
// Self-checking bench for nx_rbus_rr_arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_nx_rbus_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nx_rbus_rr_arbiter_if #(.N_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  nx_rbus_rr_arbiter #(
    .N_REQ(N), .N_RBUS_ADDR_BITS(AW), .N_RBUS_DATA_BITS(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Requester-side model state.
  logic [N-1:0]  req_v;
  logic [N-1:0]  wr_v;
  logic [AW-1:0] addr_m [N];
  logic [DW-1:0] wdata_m [N];
  int            last_grant;
  logic [N-1:0]  got_done;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Round robin from the rules: first pending requester after the last winner.
  function automatic int rr_model(input logic [N-1:0] r, input int lg);
    for (int k = 1; k <= N; k++) begin
      if (r[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  task automatic apply();
    bus.req    = req_v;
    bus.req_wr = wr_v;
    for (int n = 0; n < N; n++) begin
      bus.req_addr[n*AW +: AW]  = addr_m[n];
      bus.req_wdata[n*DW +: DW] = wdata_m[n];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_req(input int n, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!req_v[n]) begin
      req_v[n]   = 1'b1;
      wr_v[n]    = wr;
      addr_m[n]  = a;
      wdata_m[n] = d;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_v = '0;
    bus.rbus_ack = 1'b0;
    bus.rbus_err_ack = 1'b0;
    apply();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_grant = N - 1;
  endtask

  // Starts at posedge+1 of an IDLE cycle; ends at posedge+1 of the next IDLE cycle.
  // delay = WAIT cycle index (0 = strobe cycle) where the response is driven.
  task automatic do_txn(input logic [N-1:0] raise_mask, input int delay, input bit use_ok,
                        input bit use_err, input bit stray, input bit mid_drop);
    int exp_g;
    logic exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] rd_exp;
    bit acked;
    for (int n = 0; n < N; n++)
      if (raise_mask[n]) raise_req(n, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    if (req_v == '0) raise_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    exp_g     = rr_model(req_v, last_grant);
    exp_wr    = wr_v[exp_g];
    exp_addr  = addr_m[exp_g];
    exp_wdata = wdata_m[exp_g];
    rd_exp    = $urandom;
    acked     = (delay <= T - 1) && (use_ok || use_err);
    bus.rbus_ack     = stray && ($urandom_range(0, 1) == 1);
    bus.rbus_err_ack = 1'b0;
    bus.rbus_rd_data = $urandom;
    apply();
    @(negedge clk);
    check_val("idle_busy", bus.busy, 1'b0);
    check_val("idle_done", bus.req_done, '0);
    step();
    for (int w = 0; w < T; w++) begin
      bus.rbus_ack     = (w == delay) && use_ok;
      bus.rbus_err_ack = (w == delay) && use_err;
      bus.rbus_rd_data = (w == delay) ? rd_exp : $urandom;
      if (mid_drop && w == 1) req_v[$urandom_range(0, N - 1)] = 1'b0;
      apply();
      @(negedge clk);
      if (w == 0) begin
        check_val("wr_strb", bus.rbus_wr_strb, exp_wr);
        check_val("rd_strb", bus.rbus_rd_strb, !exp_wr);
        check_val("strb_addr", bus.rbus_addr, exp_addr);
        check_val("strb_wdata", bus.rbus_wr_data, exp_wdata);
      end else begin
        check_val("strb_once", {bus.rbus_wr_strb, bus.rbus_rd_strb}, 2'b00);
      end
      check_val("wait_busy", bus.busy, 1'b1);
      check_val("wait_done", bus.req_done, '0);
      if ((w == delay && (use_ok || use_err)) || w == T - 1) break;
      step();
    end
    step();
    bus.rbus_ack     = stray && ($urandom_range(0, 1) == 1);
    bus.rbus_err_ack = stray && ($urandom_range(0, 1) == 1);
    bus.rbus_rd_data = $urandom;
    @(negedge clk);
    got_done = bus.req_done;
    check_val("done_vec", bus.req_done, N'(1) << exp_g);
    check_val("done_err", bus.req_err, acked ? use_err : 1'b1);
    check_val("done_rdata", bus.req_rdata, acked ? rd_exp : '0);
    check_val("done_timeout", bus.timeout, !acked);
    check_val("rsp_busy", bus.busy, 1'b1);
    check_val("addr_hold", bus.rbus_addr, exp_addr);
    last_grant = exp_g;
    step();
    req_v[exp_g]     = 1'b0;
    bus.rbus_ack     = 1'b0;
    bus.rbus_err_ack = 1'b0;
    apply();
  endtask

  initial begin
    req_v = '0;
    wr_v  = '0;
    for (int n = 0; n < N; n++) begin
      addr_m[n]  = '0;
      wdata_m[n] = '0;
    end
    bus.rbus_rd_data = '0;
    bus.rbus_ack     = 1'b0;
    bus.rbus_err_ack = 1'b0;
    apply();
    #2;
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_done", bus.req_done, '0);
    check_val("rst_addr", bus.rbus_addr, '0);
    check_val("rst_strb", {bus.rbus_wr_strb, bus.rbus_rd_strb}, 2'b00);
    reset_dut();

    // Single write from requester 0, ack three cycles after the strobe.
    raise_req(0, 1'b1, 16'h0040, 32'hDEADBEEF);
    do_txn('0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("single_wr_done", got_done, 4'b0001);

    // Fairness: everyone keeps re-requesting reads.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < N; n++) raise_req(n, 1'b0, AW'($urandom), $urandom);
      do_txn('0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("fair_order", got_done, 4'b0001 << (i % 4));
    end

    // Error response on a read by requester 2.
    reset_dut();
    raise_req(2, 1'b0, 16'h0100, 32'h0);
    do_txn('0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("err_done", got_done, 4'b0100);

    // Timeout, then a stray ack while idle.
    raise_req(1, 1'b0, 16'h0200, 32'h0);
    do_txn('0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.rbus_ack = (i == 4);
      @(negedge clk);
      check_val("stray_busy", bus.busy, 1'b0);
      check_val("stray_done", bus.req_done, '0);
      check_val("stray_strb", {bus.rbus_wr_strb, bus.rbus_rd_strb}, 2'b00);
      step();
    end
    bus.rbus_ack = 1'b0;

    // Collisions: ack+err_ack, ack on expiry, ack in the strobe cycle.
    raise_req(3, 1'b0, 16'h0300, 32'h0);
    do_txn('0, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    raise_req(0, 1'b1, 16'h0400, 32'h11112222);
    do_txn('0, T - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    raise_req(1, 1'b0, 16'h0500, 32'h0);
    do_txn('0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of WAIT.
    reset_dut();
    raise_req(3, 1'b1, 16'h1234, 32'hA5A5A5A5);
    apply();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", bus.busy, 1'b0);
    check_val("mid_rst_done", bus.req_done, '0);
    check_val("mid_rst_addr", bus.rbus_addr, '0);
    check_val("mid_rst_wdata", bus.rbus_wr_data, '0);
    check_val("mid_rst_misc", {bus.rbus_wr_strb, bus.rbus_rd_strb, bus.req_err, bus.timeout}, 4'b0);
    req_v = '0;
    apply();
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_grant = N - 1;
    bus.rbus_ack = 1'b1;
    bus.rbus_rd_data = $urandom;
    @(negedge clk);
    check_val("late_ack_busy", bus.busy, 1'b0);
    step();
    bus.rbus_ack = 1'b0;
    @(negedge clk);
    check_val("late_ack_done", bus.req_done, '0);
    step();
    raise_req(1, 1'b0, 16'h0600, 32'h0);
    do_txn('0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("post_rst_grant", got_done, 4'b0010);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      do_txn(N'($urandom), $urandom_range(0, T + 4), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
